// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage : PC, one-outstanding imem req/ack fetch, IF/ID register + skid
// Rev 1.0
// ============================================================================
module fetch_stage #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [31:0]       imem_rdata_i,
    output logic              instr_valid_o,
    output logic [31:0]       instr_o,
    output logic [4:0]        opcode_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus1_o,
    output logic              halted_o
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [4:0] HALT_OPCODE = 5'b11111;

    state_t              state, state_d;
    logic                req, req_d;
    logic [ADDR_W-1:0]   addr, addr_d;
    logic [ADDR_W-1:0]   pc, pc_d;
    logic                valid, valid_d;
    logic [31:0]         instr, instr_d;
    logic [ADDR_W-1:0]   pc_out, pc_out_d;
    logic [ADDR_W-1:0]   pc_p1, pc_p1_d;
    logic                halted, halted_d;
    logic                skid_valid, skid_valid_d;
    logic [31:0]         skid_instr, skid_instr_d;
    logic [ADDR_W-1:0]   skid_pc, skid_pc_d;

    logic                out_free;
    logic                load_en;
    logic [31:0]         load_word;
    logic [ADDR_W-1:0]   load_pc;

    assign out_free = !valid || !stall_i;

    always_comb begin
        state_d      = state;
        req_d        = req;
        addr_d       = addr;
        pc_d         = pc;
        valid_d      = valid;
        instr_d      = instr;
        pc_out_d     = pc_out;
        pc_p1_d      = pc_p1;
        halted_d     = halted;
        skid_valid_d = skid_valid;
        skid_instr_d = skid_instr;
        skid_pc_d    = skid_pc;
        load_en      = 1'b0;
        load_word    = imem_rdata_i;
        load_pc      = addr;

        if (redirect_i) begin
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
            halted_d     = 1'b0;
            pc_d         = redirect_pc_i;
            // An unanswered request must still complete at its old address.
            if (req && !imem_ack_i) begin
                state_d = DRAIN;
            end else begin
                state_d = FETCH;
                req_d   = 1'b1;
                addr_d  = redirect_pc_i;
            end
        end else begin
            case (state)
                FETCH: begin
                    req_d = 1'b1;
                    if (req && imem_ack_i) begin
                        pc_d   = pc + ADDR_W'(1);
                        addr_d = pc + ADDR_W'(1);
                        if (out_free) begin
                            load_en = 1'b1;
                        end else begin
                            skid_valid_d = 1'b1;
                            skid_instr_d = imem_rdata_i;
                            skid_pc_d    = addr;
                            req_d        = 1'b0;
                            state_d      = HOLD;
                        end
                    end else if (out_free) begin
                        valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall_i && skid_valid) begin
                        load_en      = 1'b1;
                        load_word    = skid_instr;
                        load_pc      = skid_pc;
                        skid_valid_d = 1'b0;
                        req_d        = 1'b1;
                        state_d      = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_ack_i) begin
                        addr_d  = pc;
                        state_d = FETCH;
                    end
                end
                HALT: begin
                    req_d = 1'b0;
                    if (valid && !stall_i) begin
                        valid_d = 1'b0;
                    end
                end
                default: state_d = FETCH;
            endcase
        end

        if (load_en) begin
            instr_d  = load_word;
            pc_out_d = load_pc;
            pc_p1_d  = load_pc + ADDR_W'(1);
            valid_d  = 1'b1;
            if (load_word[31:27] == HALT_OPCODE) begin
                state_d  = HALT;
                req_d    = 1'b0;
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            req        <= 1'b0;
            addr       <= RESET_PC;
            pc         <= RESET_PC;
            valid      <= 1'b0;
            instr      <= '0;
            pc_out     <= '0;
            pc_p1      <= ADDR_W'(1);
            halted     <= 1'b0;
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else begin
            state      <= state_d;
            req        <= req_d;
            addr       <= addr_d;
            pc         <= pc_d;
            valid      <= valid_d;
            instr      <= instr_d;
            pc_out     <= pc_out_d;
            pc_p1      <= pc_p1_d;
            halted     <= halted_d;
            skid_valid <= skid_valid_d;
            skid_instr <= skid_instr_d;
            skid_pc    <= skid_pc_d;
        end
    end

    assign imem_req_o    = req;
    assign imem_addr_o   = addr;
    assign instr_valid_o = valid;
    assign instr_o       = instr;
    assign opcode_o      = valid ? instr[31:27] : 5'b00000;
    assign pc_o          = pc_out;
    assign pc_plus1_o    = pc_p1;
    assign halted_o      = halted;

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage directly upstream of the opcode decoder / control unit.
- Holds the PC and issues one-at-a-time requests to instruction memory over a req/ack handshake.
- Presents the fetched instruction, its PC and PC+1 to decode through an IF/ID output register with a one-entry skid buffer.
- Handles stall from decode, redirect from branch/jump/call/return resolution, and halt (opcode 5'b11111).

Parameters:
ADDR_W, 16, PC / instruction-memory word-address width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
stall_i  in  1  decode cannot accept; hold outputs
redirect_i  in  1  flush and load new PC
redirect_pc_i  in  ADDR_W  redirect target
imem_req_o  out  1  fetch request
imem_addr_o  out  ADDR_W  fetch word address
imem_ack_i  in  1  response valid; data on imem_rdata_i
imem_rdata_i  in  32  instruction word
instr_valid_o  out  1  instr_o/pc_o hold a live instruction
instr_o  out  32  instruction to decode
opcode_o  out  5  instr_o[31:27] when instr_valid_o=1, else 5'b00000 (NOP); combinational
pc_o  out  ADDR_W  PC of instr_o
pc_plus1_o  out  ADDR_W  pc_o+1, wraps; return address for call
halted_o  out  1  fetch stopped on halt

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, pc_o=0, pc_plus1_o=1, halted_o=0, skid empty, state FETCH, PC=RESET_PC. imem_req_o rises on the first clk edge after rst_n deasserts.
- Handshake: imem_req_o and imem_addr_o stay stable until imem_ack_i. At most one request outstanding. Ack arrives no earlier than the cycle after req rises. PC increments mod 2^ADDR_W on each accepted ack.
- FETCH (req=1):
  - Ack with output free (instr_valid_o=0 or stall_i=0): load instr/pc/pc+1 and set valid=1.
  - Ack with output valid and stall_i=1: capture the response in the skid buffer, drop req, go to HOLD.
  - No ack with output valid and stall_i=0: valid<=0 (bubble).
- HOLD (req=0): outputs frozen while stall_i=1. When stall_i=0, skid moves to the output (valid=1), skid empties, go to FETCH.
- HALT: if the word loaded into the output has [31:27]=5'b11111, go to HALT next cycle with req=0 and halted_o=1. The halt word is still presented until consumed; then valid<=0. HALT is left only by redirect or reset.
- Redirect has highest priority, over stall_i and every state:
  - Next cycle: valid=0, skid cleared, halted_o=0, PC=redirect_pc_i.
  - If a request is outstanding with no ack that cycle, go to DRAIN: req held at the old address until ack; data is discarded and no PC increment; then FETCH at the new PC.
  - If ack coincides with redirect, discard the data and go to FETCH at the new PC.
  - A second redirect during DRAIN overwrites the pending PC.
- Simultaneous stall_i and redirect_i: redirect wins and the output is flushed.
- PC wrap: 2^ADDR_W-1 increments to 0. pc_plus1_o wraps likewise.
- rst_n assertion mid-request: all state returns to reset values immediately. Any later stray ack is ignored, since req=0.
- States: FETCH, HOLD, DRAIN, HALT (2-bit encoding).

Test Plan:
- Reset, zero-wait-plus-one memory, words 0x10000000.., stall_i=0 -> addresses 0,1,2,3; valid continuously from the 3rd cycle; pc_o 0,1,2; opcode_o=5'b00010 for 0x10000000.
- stall_i=1 for 4 cycles while an ack returns -> skid captures it, req drops, outputs unchanged. Release -> skid word presented next cycle, req resumes at the next PC, no instruction lost or duplicated.
- redirect_i with target 0x0040 while a request to 0x0005 is pending and ack delayed 3 cycles -> valid=0 next cycle; 0x0005 data discarded; next req address 0x0040.
- Fetched word 0xF8000000 -> halted_o=1, req stays 0, opcode_o=5'b11111 until consumed, then 5'b00000. Redirect to 0x0010 -> fetch resumes at 0x0010.
- RESET_PC=0xFFFF, ADDR_W=16 -> fetch addresses 0xFFFF then 0x0000; pc_plus1_o=0x0000 for pc_o=0xFFFF.
- rst_n pulsed low during DRAIN -> outputs at reset values asynchronously; fetch restarts at RESET_PC.
